// File: rtl/adder_mac_pkg.sv
// rtl/adder_mac_pkg.sv - shared opcodes, mode constants and width helper for adder_mac_pipe
//
// Purpose : Opcode encodings used by stage 1 and stage 2, signed/unsigned mode
//           constants and the elaboration-time result-width rule.
// Ports   : none (package).

package adder_mac_pkg;

  // Internal 4-bit opcode: external codes 0-7 map directly, anything above
  // 7 (only possible when OP_WIDTH > 3) is folded onto OP_NOP.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_MAC = 4'd3;
  localparam logic [3:0] OP_ACC = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // A full product plus one guard bit must fit in the result width so that
  // ADD/MUL can never overflow.
  function automatic bit width_ok(input int width, input int res_width);
    return res_width >= (2 * width + 1);
  endfunction

endpackage

// File: rtl/adder_mac_pipe_stage1.sv
// rtl/adder_mac_pipe_stage1.sv - operand extension and arithmetic, registered first pipe stage
//
// Purpose : Extends a/b to RES_WIDTH (sign or zero per mode), computes the
//           non-accumulating result and the addend for MAC/ACC, and registers
//           them together with the decoded opcode and mode.
// Macro   : ADDER_MAC_SAT_EN - unsigned SUB with borrow clamps result to 0.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           load            - stage may capture new operands this cycle
//           in_valid        - operands valid
//           a, b, op, mode  - operand set
//           s1_valid        - stage holds an operation
//           s1_op, s1_mode  - decoded opcode and mode
//           s1_res          - result for ADD/SUB/MUL/AND/XOR (0 otherwise)
//           s1_addend       - value to add to acc for MAC/ACC
//           s1_flag         - unsigned SUB borrow

module adder_mac_pipe_stage1
  import adder_mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OP_WIDTH  = 3,
  parameter int RES_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 mode,
  output logic                 s1_valid,
  output logic [3:0]           s1_op,
  output logic                 s1_mode,
  output logic [RES_WIDTH-1:0] s1_res,
  output logic [RES_WIDTH-1:0] s1_addend,
  output logic                 s1_flag
);

  localparam int EXT = RES_WIDTH - WIDTH;

  logic [RES_WIDTH-1:0] a_ext;
  logic [RES_WIDTH-1:0] b_ext;
  logic [3:0]           op_int;
  logic [RES_WIDTH-1:0] res_d;
  logic [RES_WIDTH-1:0] addend_d;
  logic                 flag_d;

  always_comb begin
    a_ext    = (mode == MODE_SIGNED) ? {{EXT{a[WIDTH-1]}}, a} : {{EXT{1'b0}}, a};
    b_ext    = (mode == MODE_SIGNED) ? {{EXT{b[WIDTH-1]}}, b} : {{EXT{1'b0}}, b};
    op_int   = ((op >> 3) == '0) ? {1'b0, op[2:0]} : OP_NOP;
    res_d    = '0;
    addend_d = '0;
    flag_d   = 1'b0;
    case (op_int)
      OP_ADD: res_d = a_ext + b_ext;
      OP_SUB: begin
        res_d = a_ext - b_ext;
        if ((mode == MODE_UNSIGNED) && (a < b)) begin
          flag_d = 1'b1;
`ifdef ADDER_MAC_SAT_EN
          res_d  = '0;
`endif
        end
      end
      // Truncating the product of the extended operands gives the correct
      // two's-complement product in both modes.
      OP_MUL: res_d    = a_ext * b_ext;
      OP_MAC: addend_d = a_ext * b_ext;
      OP_ACC: addend_d = a_ext + b_ext;
      OP_AND: res_d    = RES_WIDTH'(a & b);
      OP_XOR: res_d    = RES_WIDTH'(a ^ b);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_NOP;
      s1_mode   <= MODE_UNSIGNED;
      s1_res    <= '0;
      s1_addend <= '0;
      s1_flag   <= 1'b0;
    end else if (load) begin
      s1_valid  <= in_valid;
      s1_op     <= op_int;
      s1_mode   <= mode;
      s1_res    <= res_d;
      s1_addend <= addend_d;
      s1_flag   <= flag_d;
    end
  end

endmodule

// File: rtl/adder_mac_pipe.sv
// rtl/adder_mac_pipe.sv - two-stage pipelined ALU with accumulator and valid/ready handshake
//
// Purpose : Stage 1 (sub-module) extends operands and does the arithmetic;
//           stage 2 combines with the accumulator and registers result/flag.
//           The whole pipe stalls as a unit when the sink back-pressures.
// Macro   : ADDER_MAC_SAT_EN - MAC/ACC overflow saturates acc and result,
//           unsigned SUB borrow clamps to 0. Undefined: wrap-around.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           a, b, op, mode       - operand set (mode 1 = signed)
//           in_valid / in_ready  - input handshake
//           result, flag         - output data and overflow/borrow flag
//           out_valid / out_ready- output handshake

module adder_mac_pipe
  import adder_mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OP_WIDTH  = 3,
  parameter int RES_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [RES_WIDTH-1:0] result,
  output logic                 flag,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if (!width_ok(WIDTH, RES_WIDTH)) begin : g_bad_width
    $error("adder_mac_pipe: RES_WIDTH must be >= 2*WIDTH+1");
  end

  localparam int MSB = RES_WIDTH - 1;

  logic                 advance;
  logic                 s1_valid;
  logic [3:0]           s1_op;
  logic                 s1_mode;
  logic [RES_WIDTH-1:0] s1_res;
  logic [RES_WIDTH-1:0] s1_addend;
  logic                 s1_flag;

  logic [RES_WIDTH-1:0] acc;
  logic [RES_WIDTH:0]   sum_full;
  logic [RES_WIDTH-1:0] acc_sum;
  logic [RES_WIDTH-1:0] acc_new;
  logic                 acc_ovf;
  logic [RES_WIDTH-1:0] res_d;
  logic                 flag_d;
  logic [RES_WIDTH-1:0] acc_d;
  logic                 acc_we;

  // Output register frees up whenever it is empty or being drained; stage 1
  // can additionally fill while empty even if stage 2 is stuck.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;

  adder_mac_pipe_stage1 #(
    .WIDTH     (WIDTH),
    .OP_WIDTH  (OP_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .load      (in_ready),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .s1_valid  (s1_valid),
    .s1_op     (s1_op),
    .s1_mode   (s1_mode),
    .s1_res    (s1_res),
    .s1_addend (s1_addend),
    .s1_flag   (s1_flag)
  );

`ifdef ADDER_MAC_SAT_EN
  localparam logic [RES_WIDTH-1:0] SMAX = {1'b0, {(RES_WIDTH-1){1'b1}}};
  localparam logic [RES_WIDTH-1:0] SMIN = {1'b1, {(RES_WIDTH-1){1'b0}}};
`endif

  always_comb begin
    sum_full = {1'b0, acc} + {1'b0, s1_addend};
    acc_sum  = sum_full[RES_WIDTH-1:0];
    // Signed: operands agree in sign but the sum does not. Unsigned: carry out.
    acc_ovf  = (s1_mode == MODE_SIGNED)
             ? ((acc[MSB] == s1_addend[MSB]) && (acc_sum[MSB] != acc[MSB]))
             : sum_full[RES_WIDTH];
`ifdef ADDER_MAC_SAT_EN
    // Signed overflow direction follows the (shared) operand sign; unsigned
    // accumulate only ever overflows upward.
    if (acc_ovf)
      acc_new = (s1_mode == MODE_SIGNED) ? (acc[MSB] ? SMIN : SMAX) : '1;
    else
      acc_new = acc_sum;
`else
    acc_new = acc_sum;
`endif
    res_d  = s1_res;
    flag_d = s1_flag;
    acc_d  = acc;
    acc_we = 1'b0;
    case (s1_op)
      OP_MAC, OP_ACC: begin
        acc_d  = acc_new;
        res_d  = acc_new;
        flag_d = acc_ovf;
        acc_we = 1'b1;
      end
      OP_CLR: begin
        acc_d  = '0;
        res_d  = acc;
        flag_d = 1'b0;
        acc_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_d;
        flag   <= flag_d;
        if (acc_we)
          acc <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_adder_mac_pipe.sv
// tb/tb_adder_mac_pipe.sv - self-checking bench for adder_mac_pipe

module tb_adder_mac_pipe;

  localparam int W   = 8;
  localparam int OPW = 3;
  localparam int RW  = 20;

`ifdef ADDER_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [OPW-1:0] op;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [RW-1:0]  result;
  logic           flag;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  bit [RW:0]   exp_q[$];
  bit [RW-1:0] m_acc;

  always #5 clk = ~clk;

  adder_mac_pipe #(
    .WIDTH     (W),
    .OP_WIDTH  (OPW),
    .RES_WIDTH (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flag      (flag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: mathematical value of each operation, then range check and
  // wrap/clamp into RW bits. Returns {result, flag}.
  function automatic bit [RW:0] model_op(input bit [2:0] o, input bit [W-1:0] ai,
                                         input bit [W-1:0] bi, input bit md);
    longint av, bv, accv, n, lo, hi;
    bit [RW-1:0] r;
    bit f;
    av   = md ? longint'($signed(ai)) : longint'(ai);
    bv   = md ? longint'($signed(bi)) : longint'(bi);
    accv = md ? longint'($signed(m_acc)) : longint'(m_acc);
    lo   = md ? -(longint'(1) << (RW-1)) : 0;
    hi   = md ? (longint'(1) << (RW-1)) - 1 : (longint'(1) << RW) - 1;
    r = '0;
    f = 1'b0;
    case (o)
      3'd0: r = RW'(av + bv);
      3'd1: begin
        n = av - bv;
        f = !md && (n < 0);
        r = (f && SAT) ? '0 : RW'(n);
      end
      3'd2: r = RW'(av * bv);
      3'd3, 3'd4: begin
        n = accv + ((o == 3'd3) ? av * bv : av + bv);
        f = (n < lo) || (n > hi);
        if (f && SAT) n = (n > hi) ? hi : lo;
        m_acc = RW'(n);
        r = m_acc;
      end
      3'd5: begin
        r = m_acc;
        m_acc = '0;
      end
      3'd6: r = RW'(ai & bi);
      default: r = RW'(ai ^ bi);
    endcase
    return {r, f};
  endfunction

  // One clock: observe handshakes mid-cycle, then move past the next edge.
  task automatic cycle();
    bit [RW:0] e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_output: observed result %h with no op outstanding", result);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", 32'(result), 32'(e[RW:1]));
        chk("sb_flag", 32'(flag), 32'(e[0]));
      end
    end
    if (!rst && in_valid && in_ready)
      exp_q.push_back(model_op(op, a, b, mode));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  // Single op into an empty pipe, checking latency and the expected output.
  task automatic issue_check(input string tag, input bit [2:0] o, input bit [W-1:0] ai,
                             input bit [W-1:0] bi, input bit md,
                             input bit [RW-1:0] er, input bit ef);
    op = o; a = ai; b = bi; mode = md;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    cycle();
    chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flag"}, 32'(flag), 32'(ef));
    cycle();
  endtask

  initial begin
    logic [RW-1:0] held;
    rst = 1'b1; a = '0; b = '0; op = '0; mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    m_acc = '0;
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    issue_check("add", 3'd0, 8'd200, 8'd100, 1'b0, 20'd300, 1'b0);
    issue_check("sub_u", 3'd1, 8'd5, 8'd10, 1'b0, SAT ? 20'h00000 : 20'hFFFFB, 1'b1);
    issue_check("sub_s", 3'd1, 8'd5, 8'd10, 1'b1, 20'hFFFFB, 1'b0);

    // CLR, then two back-to-back signed MACs: -12, then 88.
    issue_check("clr0", 3'd5, 8'd0, 8'd0, 1'b0, 20'd0, 1'b0);
    op = 3'd3; a = 8'hFD; b = 8'd4; mode = 1'b1; in_valid = 1'b1;
    cycle();
    a = 8'd10; b = 8'd10;
    cycle();
    drain();
    issue_check("clr88", 3'd5, 8'd0, 8'd0, 1'b0, 20'd88, 1'b0);

    // Back-pressure: two ops fill the pipe, then input stalls and output holds.
    op = 3'd0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 8'(i + 1); b = 8'(i * 3);
      cycle();
      if (i >= 1) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (i == 1) held = result;
        else chk("stall_result_stable", 32'(result), 32'(held));
      end
    end
    chk("stall_outstanding", 32'(exp_q.size()), 32'd2);
    drain();

    // 17 unsigned 255*255 MACs: the 17th overflows 20 bits.
    issue_check("clr_pre_ovf", 3'd5, 8'd0, 8'd0, 1'b0, 20'd0, 1'b0);
    op = 3'd3; a = 8'd255; b = 8'd255; mode = 1'b0; in_valid = 1'b1;
    repeat (17) cycle();
    drain();
    issue_check("clr_post_ovf", 3'd5, 8'd0, 8'd0, 1'b0, SAT ? 20'hFFFFF : 20'h0DE11, 1'b0);

    // Reset with two ops in flight discards them and clears the accumulator.
    op = 3'd3; a = 8'd5; b = 8'd5; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_acc = '0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flag", 32'(flag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    issue_check("mac_after_rst", 3'd3, 8'd1, 8'd1, 1'b0, 20'd1, 1'b0);

    // Random traffic with random back-pressure against the reference model.
    for (int i = 0; i < 400; i++) begin
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      mode      = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_mac_pipe.md
Name: adder_mac_pipe

Overview:
- Next-generation arithmetic unit: parametrised two-stage pipelined ALU with an internal accumulator, signed/unsigned mode and a valid/ready handshake on both sides.
- Supersedes the single-cycle adder in datapath slots that need back-pressure and multiply-accumulate.
- Sits between an operand source (sequencer/FIFO) and a result sink; one operation accepted per cycle at full throughput.

Parameters:
- WIDTH, 8, operand width of a and b.
- OP_WIDTH, 3, opcode width; only codes 0-7 defined, upper codes (if OP_WIDTH>3) execute as NOP.
- RES_WIDTH, 20, result/accumulator width; must satisfy RES_WIDTH >= 2*WIDTH+1 (elaboration-time check, $error otherwise).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  OP_WIDTH  opcode.
- mode  in  1  1 = signed (two's complement), 0 = unsigned; sampled with operands.
- in_valid  in  1  operand set valid.
- in_ready  out  1  unit can accept operands this cycle.
- result  out  RES_WIDTH  operation result.
- flag  out  1  overflow/borrow indicator for the result.
- out_valid  out  1  result/flag valid.
- out_ready  in  1  sink accepts result this cycle.

Behaviour:
- Reset (rst=1 at posedge): stage valids=0, out_valid=0, result=0, flag=0, accumulator=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight ops with no output.
- Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
- in_ready = !s1_valid || advance, where advance = !out_valid || out_ready; whole pipe stalls as a unit, with no bubbles and no dropped or duplicated results.
- Latency: exactly 2 cycles from input transfer to out_valid when not stalled; throughput 1/cycle.
- Stage 1: extend a, b to RES_WIDTH (sign-extend if mode=1, else zero-extend); compute sum/diff/product/logic; register op and mode.
- Stage 2: accumulator ops combine with acc; register result and flag; acc updated only when the stage-2 op advances.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 MUL: a*b.
  - 3 MAC: acc <= acc + a*b; result = new acc.
  - 4 ACC: acc <= acc + a + b; result = new acc.
  - 5 CLR: acc <= 0; result = old acc; flag=0.
  - 6 AND: bitwise on zero-extended operands.
  - 7 XOR: bitwise on zero-extended operands.
- Back-to-back MAC/ACC: no hazard; each op sees acc including all previous accepted ops.
- Flag:
  - ADD/MUL: cannot overflow given the width rule; flag=0.
  - SUB unsigned: flag = borrow (a<b); result wraps modulo 2^RES_WIDTH.
  - SUB signed: flag=0.
  - MAC/ACC: flag = RES_WIDTH overflow of the accumulate (signed overflow if mode=1, carry-out if mode=0). Wrap is the default behaviour.
  - AND/XOR: flag=0.
- Stall: result/flag/out_valid held stable while out_valid && !out_ready.

Optional Feature:
- Macro ADDER_MAC_SAT_EN.
- Defined: MAC/ACC overflow saturates acc and result to max/min representable (signed: 2^(RES_WIDTH-1)-1 / -2^(RES_WIDTH-1); unsigned: 2^RES_WIDTH-1); flag=1 in the saturating cycle. Unsigned SUB with borrow clamps result to 0, flag=1.
- Undefined: wrap modulo 2^RES_WIDTH, flag as above.

Decomposition:
- Package adder_mac_pkg:
  - opcode localparams OP_ADD..OP_XOR.
  - MODE_UNSIGNED/MODE_SIGNED constants.
  - function for width-check/extension.
- Sub-module adder_mac_stage1: combinational extend plus arithmetic with registered outputs.
- Accumulator, stage 2 and handshake stay in the top module.

Test Plan:
- Reset then ADD a=8'd200, b=8'd100, mode=0 -> 2 cycles later out_valid=1, result=20'd300, flag=0.
- SUB a=8'd5, b=8'd10: mode=0 -> result=20'hFFFFB, flag=1; mode=1 -> result=20'hFFFFB (-5), flag=0.
- CLR, then MAC (a=-3, b=4, mode=1), then MAC (a=10, b=10), back-to-back -> results 20'hFFFF4 (-12), then 20'd88; final CLR returns 88, flag=0.
- Hold out_ready=0 for 5 cycles with in_valid=1 continuously -> in_ready drops after pipe fills (2 ops held), result stable; release -> all ops emitted in order, none lost.
- Unsigned MAC 255*255 repeated until acc exceeds 2^20-1 (17th op) -> flag=1 on the overflow op; wraps without macro, saturates at 20'hFFFFF with ADDER_MAC_SAT_EN.
- Assert rst with 2 ops in flight -> next cycle out_valid=0, result=0; a following MAC a=1, b=1 returns 1 (acc cleared).
